// File: rtl/bin_to_bcd_seq_ctrl.sv
// Sequential binary-to-BCD converter: one shift-and-add-3 iteration per clock,
// with valid/ready handshakes towards the binary producer and the BCD consumer.
module bin_to_bcd_seq_ctrl #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5,
  parameter int CNT_W  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  busy
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both 1. in_ready/out_valid depend only on state, never on in_valid or
  // out_ready, so there is no combinational path between the two sides.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  state_t                state;
  logic [WIDTH-1:0]      bin_q;
  logic [4*DIGITS-1:0]   acc_q;
  logic [4*DIGITS-1:0]   acc_adj;
  logic [4*DIGITS-1:0]   acc_next;
  logic [CNT_W-1:0]      cnt_q;

  // Per-digit add-3 with no carry between digits; a digit >= 5 doubles past 9.
  always_comb begin
    acc_adj = acc_q;
    for (int d = 0; d < DIGITS; d++) begin
      if (acc_q[4*d +: 4] >= 4'd5) begin
        acc_adj[4*d +: 4] = acc_q[4*d +: 4] + 4'd3;
      end
    end
  end

  // Whatever leaves the top digit is dropped, which yields value mod 10^DIGITS.
  assign acc_next = {acc_adj[4*DIGITS-2:0], bin_q[WIDTH-1]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      bin_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      out_bcd <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            bin_q <= in_data;
            acc_q <= '0;
            cnt_q <= CNT_INIT;
            state <= CONV;
          end
        end
        CONV: begin
          acc_q <= acc_next;
          bin_q <= {bin_q[WIDTH-2:0], 1'b0};
          cnt_q <= cnt_q - CNT_LAST;
          if (cnt_q == CNT_LAST) begin
            out_bcd <= acc_next;
            state   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state == CONV);
  assign out_valid = (state == DONE);

endmodule

// File: tb/tb_bin_to_bcd_seq_ctrl.sv
// Directed bench for bin_to_bcd_seq_ctrl: default, truncated (3-digit) and
// 8-bit instances, with a scoreboard for the 8-bit handshake sweep.
module tb_bin_to_bcd_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT A: WIDTH=16, DIGITS=5
  logic        a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b0, a_busy;
  logic [15:0] a_in_data = '0;
  logic [19:0] a_out_bcd;

  bin_to_bcd_seq_ctrl #(.WIDTH(16), .DIGITS(5), .CNT_W(5)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_bcd(a_out_bcd),
    .busy(a_busy)
  );

  // ---------------- DUT B: WIDTH=16, DIGITS=3 (truncation)
  logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0, b_busy;
  logic [15:0] b_in_data = '0;
  logic [11:0] b_out_bcd;

  bin_to_bcd_seq_ctrl #(.WIDTH(16), .DIGITS(3), .CNT_W(5)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_bcd(b_out_bcd),
    .busy(b_busy)
  );

  // ---------------- DUT C: WIDTH=8, DIGITS=3 (sweep)
  logic        c_in_valid = 1'b0, c_in_ready, c_out_valid, c_out_ready = 1'b0, c_busy;
  logic [7:0]  c_in_data = '0;
  logic [11:0] c_out_bcd;

  bin_to_bcd_seq_ctrl #(.WIDTH(8), .DIGITS(3), .CNT_W(4)) dut_c (
    .clk(clk), .rst_n(rst_n),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_bcd(c_out_bcd),
    .busy(c_busy)
  );

  logic [31:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Decimal-to-BCD reference using division, independent of double-dabble.
  function automatic logic [31:0] to_bcd(input int value, input int digits);
    logic [31:0] r;
    int v;
    r = '0;
    v = value;
    for (int d = 0; d < digits; d++) begin
      r[4*d +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Offer v to DUT A, wait for acceptance, then wait for out_valid.
  // Returns on the negedge where out_valid is first seen (or after a timeout).
  task automatic convert_a(input logic [15:0] v, input logic [19:0] prev_bcd,
                           output int lat, output int busy_n, output int acc_cyc);
    int g;
    a_in_valid = 1'b1;
    a_in_data  = v;
    g = 0;
    while (!a_in_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    check_eq("accept_wait", 32'(a_in_ready), 32'd1);
    acc_cyc = cyc;
    @(negedge clk);
    a_in_valid = 1'b0;
    a_in_data  = 16'(~v);
    check_eq("in_ready_drop", 32'(a_in_ready), 32'd0);
    check_eq("bcd_held_in_conv", 32'(a_out_bcd), 32'(prev_bcd));
    lat = 0;
    busy_n = 0;
    while (!a_out_valid && lat < 100) begin
      busy_n += int'(a_busy);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release_a();
    a_out_ready = 1'b1;
    @(negedge clk);
    a_out_ready = 1'b0;
    check_eq("in_ready_after_release", 32'(a_in_ready), 32'd1);
    check_eq("out_valid_after_release", 32'(a_out_valid), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, busy_n, c0, c1, c2;
    logic saw_valid;
    logic stable;
    logic [15:0] tv[3];
    logic [19:0] te[3];

    // ---------- reset
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_in_ready", 32'(a_in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(a_out_valid), 32'd0);
    check_eq("rst_busy", 32'(a_busy), 32'd0);
    check_eq("rst_out_bcd", 32'(a_out_bcd), 32'd0);
    check_eq("rst_c_in_ready", 32'(c_in_ready), 32'd1);

    // ---------- test 1: 0xFFFF
    convert_a(16'hFFFF, 20'h00000, lat, busy_n, c0);
    check_eq("t1_latency", 32'(lat), 32'd16);
    check_eq("t1_busy_cycles", 32'(busy_n), 32'd16);
    check_eq("t1_out_valid", 32'(a_out_valid), 32'd1);
    check_eq("t1_out_bcd", 32'(a_out_bcd), 32'h65535);
    release_a();

    // ---------- test 2: 255, 0, 9 with out_ready tied high
    tv[0] = 16'd255; te[0] = 20'h00255;
    tv[1] = 16'd0;   te[1] = 20'h00000;
    tv[2] = 16'd9;   te[2] = 20'h00009;
    a_out_ready = 1'b1;
    convert_a(tv[0], 20'h65535, lat, busy_n, c0);
    check_eq("t2_bcd_255", 32'(a_out_bcd), 32'(te[0]));
    convert_a(tv[1], te[0], lat, busy_n, c1);
    check_eq("t2_bcd_0", 32'(a_out_bcd), 32'(te[1]));
    check_eq("t2_latency_0", 32'(lat), 32'd16);
    convert_a(tv[2], te[1], lat, busy_n, c2);
    check_eq("t2_bcd_9", 32'(a_out_bcd), 32'(te[2]));
    check_eq("t2_spacing_1", 32'(c1 - c0), 32'd18);
    check_eq("t2_spacing_2", 32'(c2 - c1), 32'd18);
    @(negedge clk);
    a_out_ready = 1'b0;
    check_eq("t2_idle_after", 32'(a_in_ready), 32'd1);

    // ---------- test 3: backpressure on 1234
    convert_a(16'd1234, 20'h00009, lat, busy_n, c0);
    check_eq("t3_out_bcd", 32'(a_out_bcd), 32'h01234);
    stable = 1'b1;
    a_in_valid = 1'b1;
    a_in_data  = 16'd777;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!a_out_valid || a_out_bcd !== 20'h01234 || a_in_ready || a_busy) stable = 1'b0;
    end
    check_eq("t3_stable_hold", 32'(stable), 32'd1);
    a_in_valid = 1'b0;
    release_a();
    @(negedge clk);
    check_eq("t3_ignored_req", 32'(a_busy), 32'd0);
    check_eq("t3_bcd_in_idle", 32'(a_out_bcd), 32'h01234);

    // ---------- test 4: reset mid-conversion of 40000
    a_in_valid = 1'b1;
    a_in_data  = 16'd40000;
    @(negedge clk);
    a_in_valid = 1'b0;
    repeat (7) @(negedge clk);
    check_eq("t4_busy_before_rst", 32'(a_busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("t4_out_valid", 32'(a_out_valid), 32'd0);
    check_eq("t4_busy", 32'(a_busy), 32'd0);
    check_eq("t4_out_bcd", 32'(a_out_bcd), 32'd0);
    check_eq("t4_in_ready", 32'(a_in_ready), 32'd1);
    saw_valid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      saw_valid = saw_valid | a_out_valid;
    end
    check_eq("t4_no_result", 32'(saw_valid), 32'd0);
    check_eq("t4_bcd_still_zero", 32'(a_out_bcd), 32'd0);

    // ---------- test 5: truncation, 65535 with 3 digits
    b_in_valid = 1'b1;
    b_in_data  = 16'hFFFF;
    @(negedge clk);
    b_in_valid = 1'b0;
    lat = 0;
    while (!b_out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check_eq("t5_latency", 32'(lat), 32'd16);
    check_eq("t5_out_bcd", 32'(b_out_bcd), 32'h535);
    b_out_ready = 1'b1;
    @(negedge clk);
    b_out_ready = 1'b0;
    check_eq("t5_release", 32'(b_in_ready), 32'd1);

    // ---------- test 6: 8-bit sweep with random handshakes
    fork
      begin : producer
        int g;
        for (int v = 0; v < 256; v++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          c_in_valid = 1'b1;
          c_in_data  = 8'(v);
          g = 0;
          while (!c_in_ready && g < 200) begin
            @(negedge clk);
            g++;
          end
          if (!c_in_ready) check_eq("t6_accept_wait", 32'(c_in_ready), 32'd1);
          exp_q.push_back(to_bcd(v, 3));
          @(negedge clk);
          c_in_valid = 1'b0;
          c_in_data  = 8'($urandom_range(0, 255));
        end
      end
      begin : consumer
        int got;
        int budget;
        logic rdy;
        logic [31:0] e;
        got = 0;
        budget = 0;
        while (got < 256 && budget < 20000) begin
          @(negedge clk);
          budget++;
          rdy = ($urandom_range(0, 2) != 0);
          if (c_out_valid && rdy) begin
            if (exp_q.size() == 0) begin
              check_eq("t6_unexpected_out", 32'(c_out_bcd), 32'hFFFFFFFF);
            end else begin
              e = exp_q.pop_front();
              check_eq("t6_bcd", 32'(c_out_bcd), e);
            end
            got++;
          end
          c_out_ready = rdy;
        end
        @(negedge clk);
        c_out_ready = 1'b0;
        check_eq("t6_count", 32'(got), 32'd256);
      end
    join
    saw_valid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      saw_valid = saw_valid | c_out_valid;
    end
    check_eq("t6_no_duplicate", 32'(saw_valid), 32'd0);
    check_eq("t6_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
